// File: rtl/result_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble, one shift per clock) feeding a
// 4-digit common-anode 7-segment scan driver that keeps showing the last result.
module result_display_driver #(
    parameter int REFRESH_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  value,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Segment code used for both blanked digits and the unreachable nibbles 10-15.
    localparam logic [3:0] BLANK_NIB = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t           state;
    logic [7:0]       bin_sr;
    logic [11:0]      scratch;
    logic [11:0]      scratch_adj;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       digit_nib;

    function automatic logic [3:0] dabble(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign scratch_adj = {dabble(scratch[11:8]), dabble(scratch[7:4]), dabble(scratch[3:0])};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= 12'h000;
            bin_sr  <= 8'h00;
            scratch <= 12'h000;
            bit_cnt <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr  <= value;
                        scratch <= 12'h000;
                        bit_cnt <= 3'd7;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Max input is 255, so the adjusted hundreds nibble never reaches bit 11.
                    {scratch, bin_sr} <= {scratch_adj[10:0], bin_sr, 1'b0};
                    bit_cnt           <= bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= scratch;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // NOTE: digit_nib gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        digit_nib = BLANK_NIB;
        case (digit_idx)
            2'd0: digit_nib = bcd[3:0];
            2'd1: digit_nib = (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? BLANK_NIB : bcd[7:4];
            2'd2: digit_nib = (bcd[11:8] == 4'd0) ? BLANK_NIB : bcd[11:8];
            default: digit_nib = BLANK_NIB;
        endcase
    end

    // Anode and segments both derive from the registered digit_idx, so they switch together.
    assign an  = ~(4'b0001 << digit_idx);
    assign seg = decode(digit_nib);
    assign dp  = 1'b1;

endmodule

// File: tb/tb_result_display_driver.sv
// Randomized scoreboard bench for result_display_driver: expected BCD results are queued
// at load time and checked whenever done pulses; the scan is checked against cycle counts.
module tb_result_display_driver;

    localparam int REFRESH_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [7:0]  value;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int shown = 0;
    logic [11:0] exp_q[$];

    logic [6:0] font_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    result_display_driver #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge; the scan position follows from this alone.
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] golden(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with bcd %0h expected no pulse", bcd);
                end else begin
                    check("bcd_result", 32'(bcd), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        exp_q.delete();
        shown = 0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd",  32'(bcd),  32'h000);
        check("rst_an",   32'(an),   32'b1110);
        check("rst_seg",  32'(seg),  32'b1000000);
        check("rst_dp",   32'(dp),   32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    // junk: 0 = quiet while busy, 1 = random loads while busy, 2 = load value 7 every busy cycle.
    task automatic do_conv(input int v, input int junk, input bit chk_busy);
        @(negedge clk);
        load  = 1'b1;
        value = 8'(v);
        exp_q.push_back(golden(v));
        shown = v;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (chk_busy) check("busy_high", 32'(busy), 32'd1);
            if (junk == 2) begin
                load  = 1'b1;
                value = 8'd7;
            end else if (junk == 1) begin
                load  = 1'($urandom_range(0, 1));
                value = 8'($urandom);
            end else begin
                load = 1'b0;
            end
        end
        if (chk_busy) begin
            @(negedge clk);
            load = 1'b0;
            check("busy_low",   32'(busy), 32'd0);
            check("done_pulse", 32'(done), 32'd1);
        end
    endtask

    task automatic check_scan(input int n);
        int d;
        logic [6:0] exp_seg;
        repeat (n) begin
            @(negedge clk);
            load = 1'b0;
            d = (k / REFRESH_DIV) % 4;
            case (d)
                0: exp_seg = font_tab[shown % 10];
                1: exp_seg = (shown >= 10)  ? font_tab[(shown / 10) % 10] : 7'b1111111;
                2: exp_seg = (shown >= 100) ? font_tab[shown / 100] : 7'b1111111;
                default: exp_seg = 7'b1111111;
            endcase
            check("scan", 32'({dp, an, seg}), 32'({1'b1, an_tab[d], exp_seg}));
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = 8'd0;
        apply_reset();

        // Single conversion with busy/done timing.
        do_conv(100, 0, 1'b1);
        idle(2);

        // Back-to-back extremes, then the display of zero.
        do_conv(255, 0, 1'b0);
        do_conv(0, 0, 1'b0);
        idle(3);
        check_scan(16);

        // Loads during SHIFT and DONE must be ignored.
        do_conv(100, 2, 1'b0);
        idle(3);

        // Reset in the 4th SHIFT cycle aborts the conversion without a done pulse.
        @(negedge clk);
        load  = 1'b1;
        value = 8'd200;
        exp_q.push_back(golden(200));
        repeat (3) begin
            @(negedge clk);
            load = 1'b0;
        end
        apply_reset();
        do_conv(42, 0, 1'b0);
        idle(3);
        check_scan(16);

        // Exhaustive sweep with random interfering loads.
        for (int v = 0; v < 256; v++) begin
            do_conv(v, (v % 3 == 0) ? 1 : 0, 1'b0);
        end
        idle(2);

        // Random values with random gaps.
        for (int i = 0; i < 40; i++) begin
            do_conv(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1'b0);
            idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        check_scan(16);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
